abr_arbiter: RTL and testbench

ABR_ARBITER -- requirements
Module: abr_arbiter

---
 rtl/abr_pkg.sv | 15 +
 rtl/abr_hold_cnt.sv | 29 ++
 rtl/abr_arbiter.sv | 93 +++++++++
 tb/tb_abr_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/abr_pkg.sv
// Shared types and constants for the two-requester round-robin arbiter.
package abr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } abr_state_t;

  localparam int ABR_NUM_REQ      = 2;
  localparam int ABR_MAX_HOLD_DEF = 8;
  // Wide enough for any legal MAX_HOLD (2..255).
  localparam int ABR_CNT_W        = 8;

endpackage

// File: rtl/abr_hold_cnt.sv
// Saturating tenure counter: loads 1 on grant entry, clears on return to idle,
// otherwise counts grant cycles up to MAX_HOLD and holds there.
module abr_hold_cnt
  import abr_pkg::*;
#(
  parameter int unsigned MAX_HOLD = ABR_MAX_HOLD_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 clr,
  output logic [ABR_CNT_W-1:0] cnt
);

  localparam logic [ABR_CNT_W-1:0] HOLD_LIM = ABR_CNT_W'(MAX_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= ABR_CNT_W'(1);
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != HOLD_LIM) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/abr_arbiter.sv
// Two-requester round-robin arbiter with registered one-hot grant.
// Optional tenure timeout is compiled in with `define ABR_TIMEOUT_EN.
module abr_arbiter
  import abr_pkg::*;
#(
  parameter int unsigned MAX_HOLD = ABR_MAX_HOLD_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ABR_NUM_REQ-1:0] request,
  output logic [ABR_NUM_REQ-1:0] grant,
  output logic                   busy
);

  abr_state_t state, state_nxt;
  logic       last_gnt, last_gnt_nxt;
  logic       timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (request == 2'b11)   state_nxt = last_gnt ? GNT0 : GNT1;
        else if (request[0])    state_nxt = GNT0;
        else if (request[1])    state_nxt = GNT1;
      end
      GNT0: begin
        if (!request[0])                state_nxt = request[1] ? GNT1 : IDLE;
        else if (timeout && request[1]) state_nxt = GNT1;
      end
      GNT1: begin
        if (!request[1])                state_nxt = request[0] ? GNT0 : IDLE;
        else if (timeout && request[0]) state_nxt = GNT0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pointer remembers the most recent owner so the other side wins the next tie.
  always_comb begin
    last_gnt_nxt = last_gnt;
    if (state_nxt == GNT0)      last_gnt_nxt = 1'b0;
    else if (state_nxt == GNT1) last_gnt_nxt = 1'b1;
  end

`ifdef ABR_TIMEOUT_EN
  logic [ABR_CNT_W-1:0] hold_cnt;
  logic                 tenure_start;
  logic                 tenure_end;

  assign tenure_start = (state_nxt != IDLE) && (state_nxt != state);
  assign tenure_end   = (state_nxt == IDLE);

  abr_hold_cnt #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tenure_start),
    .clr   (tenure_end),
    .cnt   (hold_cnt)
  );

  assign timeout = (hold_cnt == ABR_CNT_W'(MAX_HOLD));
`else
  logic unused_max_hold;
  assign unused_max_hold = ^MAX_HOLD;
  assign timeout         = 1'b0;
`endif

  // Outputs decode straight from the state register, so reset clears them at once.
  always_comb begin
    grant = '0;
    case (state)
      GNT0:    grant = 2'b01;
      GNT1:    grant = 2'b10;
      default: grant = '0;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_abr_arbiter.sv
// Self-checking bench for abr_arbiter: table-driven vectors plus hand-written
// sequences for hold, handover, pulse rejection and asynchronous reset.
module tb_abr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] request;
  logic [1:0] grant;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] req;
    logic [1:0] gnt;
  } vec_t;

  vec_t tbl[14];

  abr_arbiter #(.MAX_HOLD(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .request (request),
    .grant   (grant),
    .busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [1:0] exp_g);
    logic exp_b;
    exp_b = |exp_g;
    checks++;
    if (grant !== exp_g) begin
      errors++;
      $display("FAIL %s: grant=%b expected=%b at %0t", name, grant, exp_g, $time);
    end
    checks++;
    if (busy !== exp_b) begin
      errors++;
      $display("FAIL %s: busy=%b expected=%b at %0t", name, busy, exp_b, $time);
    end
  endtask

  // Drive request, let one rising edge sample it, then check just after the edge.
  task automatic step(input logic [1:0] r, input logic [1:0] exp_g, input string name);
    request = r;
    @(posedge clk);
    #1;
    chk(name, exp_g);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (grant === 2'b11 || busy !== (|grant)) begin
        errors++;
        $display("FAIL invariant: grant=%b busy=%b at %0t", grant, busy, $time);
      end
    end
  end

  a_grant_legal: assert property (@(posedge clk) disable iff (!rst_n)
    (grant != 2'b11) && (busy == |grant));

  initial begin
    // Starting with last owner = requester 0 (left by the earlier sequences).
    tbl[0]  = '{2'b00, 2'b00};
    tbl[1]  = '{2'b01, 2'b01};
    tbl[2]  = '{2'b01, 2'b01};
    tbl[3]  = '{2'b00, 2'b00};
    tbl[4]  = '{2'b11, 2'b10};
    tbl[5]  = '{2'b11, 2'b10};
    tbl[6]  = '{2'b01, 2'b01};
    tbl[7]  = '{2'b11, 2'b01};
    tbl[8]  = '{2'b10, 2'b10};
    tbl[9]  = '{2'b00, 2'b00};
    tbl[10] = '{2'b10, 2'b10};
    tbl[11] = '{2'b00, 2'b00};
    tbl[12] = '{2'b11, 2'b01};
    tbl[13] = '{2'b00, 2'b00};

    rst_n   = 1'b0;
    request = 2'b11;
    #12;
    chk("reset_state", 2'b00);
    rst_n = 1'b1;

    step(2'b11, 2'b01, "first_tie_req0");
`ifdef ABR_TIMEOUT_EN
    for (int i = 1; i < 8; i++) step(2'b11, 2'b01, "timeout_hold0");
    for (int i = 0; i < 8; i++) step(2'b11, 2'b10, "timeout_hold1");
    step(2'b11, 2'b01, "timeout_back0");
`else
    for (int i = 1; i < 50; i++) step(2'b11, 2'b01, "no_timeout_hold");
`endif
    step(2'b00, 2'b00, "release_idle");

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].req, tbl[i].gnt, $sformatf("table_%0d", i));
    end

    for (int i = 0; i < 5; i++) step(2'b01, 2'b01, "hold5_req0");
    step(2'b00, 2'b00, "hold5_drop");

    step(2'b01, 2'b01, "handover_own");
    step(2'b11, 2'b01, "handover_both");
    step(2'b10, 2'b10, "handover_nogap");
    step(2'b00, 2'b00, "handover_idle");

    // Pulse that rises and falls between edges is never sampled.
    request = 2'b01;
    #3;
    request = 2'b00;
    @(posedge clk);
    #1;
    chk("missed_pulse", 2'b00);

    step(2'b01, 2'b01, "sampled_pulse");
    step(2'b00, 2'b00, "sampled_pulse_rel");

    step(2'b10, 2'b10, "pre_reset_gnt1");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_drop", 2'b00);
    #3;
    rst_n   = 1'b1;
    step(2'b11, 2'b01, "post_reset_tie");
    step(2'b00, 2'b00, "final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
